alien_wave_ctrl: RTL and testbench

- Formation scheduler for the alien array in the gatorga playfield.
- Sequences per-frame march/descend motion of an N-alien grid and owns each alien's alive/enable bit.
- Arbitrates hit reports from the per-alien instances against the single player bullet, consuming the bullet and scoring at most one kill per shot.
- Respawns waves after a clear delay; declares game over when the formation reaches the player row.

---
 rtl/gatorga_pkg.sv | 37 +++
 rtl/alien_wave_ctrl_hit_arbiter.sv | 21 ++
 rtl/alien_wave_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alien_wave_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gatorga_pkg.sv
// Shared types and playfield geometry for the gatorga alien formation logic.
package gatorga_pkg;

  // Formation scheduler phases.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SPAWN      = 3'd1,
    ST_MARCH      = 3'd2,
    ST_DESCEND    = 3'd3,
    ST_WAVE_CLEAR = 3'd4,
    ST_GAME_OVER  = 3'd5
  } wave_state_t;

  // Playfield coordinates are 12-bit signed.
  typedef logic signed [11:0] coord_t;

  // Playfield geometry: the formation keeps a border margin on both sides
  // and loses once it reaches the player row.
  localparam int PF_BORDER    = 16;
  localparam int PF_WIDTH     = 416;
  localparam int PLAYER_ROW_Y = 400;

  localparam int FORMATION_X_MIN   = PF_BORDER;
  localparam int FORMATION_X_MAX   = PF_WIDTH - PF_BORDER;
  localparam int FORMATION_Y_LIMIT = PLAYER_ROW_Y;

  // Width of an alien slot index (up to 16 slots).
  localparam int HIT_IDX_W = 4;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/alien_wave_ctrl_hit_arbiter.sv
// Lowest-index priority encoder choosing which alien a bullet kills.
module hit_arbiter
  import gatorga_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [HIT_IDX_W-1:0] index
);

  // Scan from the top down so the lowest set request wins last.
  always_comb begin
    valid = |req;
    index = {HIT_IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      index = req[i] ? HIT_IDX_W'(i) : index;
    end
  end

endmodule

// File: rtl/alien_wave_ctrl.sv
// Alien formation scheduler: march/descend motion, per-alien alive mask,
// one-kill-per-shot hit arbitration, wave respawn and game-over detection.
module alien_wave_ctrl
  import gatorga_pkg::*;
#(
  parameter int N_ALIENS     = 8,
  parameter int X_START      = 100,
  parameter int Y_START      = 40,
  parameter int X_MIN        = FORMATION_X_MIN,
  parameter int X_MAX        = FORMATION_X_MAX,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 8,
  parameter int Y_LIMIT      = FORMATION_Y_LIMIT,
  parameter int STEP_FRAMES  = 2,
  parameter int CLEAR_FRAMES = 60,
  parameter int POINTS       = 10
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 fsync,
  input  logic                 bullet_active,
  input  logic [N_ALIENS-1:0]  alien_hit,
  output logic [N_ALIENS-1:0]  alien_enable,
  output coord_t               formation_x,
  output coord_t               formation_y,
  output logic                 bullet_consume,
  output logic [HIT_IDX_W-1:0] hit_index,
  output logic [15:0]          score,
  output logic [7:0]           wave_num,
  output logic                 game_over
);

  localparam logic [N_ALIENS-1:0] ALL_ALIVE = {N_ALIENS{1'b1}};
  localparam logic [N_ALIENS-1:0] NO_ALIEN  = {N_ALIENS{1'b0}};
  localparam logic [N_ALIENS-1:0] ONE_ALIEN = N_ALIENS'(1'b1);

  localparam coord_t X_START_C = coord_t'(X_START);
  localparam coord_t Y_START_C = coord_t'(Y_START);
  localparam coord_t STEP_X_C  = coord_t'(STEP_X);

  // Bound checks run one bit wider so x +/- step can never wrap.
  localparam logic signed [12:0] STEP_X_W  = 13'(STEP_X);
  localparam logic signed [12:0] STEP_Y_W  = 13'(STEP_Y);
  localparam logic signed [12:0] X_MIN_W   = 13'(X_MIN);
  localparam logic signed [12:0] X_MAX_W   = 13'(X_MAX);
  localparam logic signed [12:0] Y_LIMIT_W = 13'(Y_LIMIT);

  localparam logic [15:0] STEP_LAST  = 16'(STEP_FRAMES - 1);
  localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_FRAMES - 1);
  localparam logic [15:0] POINTS_C   = 16'(POINTS);

  wave_state_t state_r, state_s;

  logic [N_ALIENS-1:0]  enable_r, enable_s;
  coord_t               x_r, x_s;
  coord_t               y_r, y_s;
  logic                 dir_left_r, dir_left_s;
  logic [15:0]          cnt_r, cnt_s;
  logic [15:0]          score_r, score_s;
  logic [7:0]           wave_r, wave_s;
  logic [HIT_IDX_W-1:0] hit_index_r, hit_index_s;
  logic                 consume_r, consume_s;
  logic                 lockout_r, lockout_s;
  logic                 game_over_r, game_over_s;

  logic [N_ALIENS-1:0]  live_hits_s;
  logic                 hit_valid_s;
  logic [HIT_IDX_W-1:0] hit_idx_s;
  logic                 hunting_s;
  logic                 accept_s;
  logic [N_ALIENS-1:0]  kill_bit_s;
  logic [N_ALIENS-1:0]  mask_after_s;
  logic                 mask_empty_s;
  logic                 step_due_s;
  logic                 clear_due_s;
  logic signed [12:0]   x_wide_s;
  logic signed [12:0]   y_wide_s;
  logic signed [12:0]   y_desc_s;
  logic                 x_blocked_s;
  logic                 y_over_s;

  // Only aliens still alive can be hit.
  assign live_hits_s = alien_hit & enable_r;

  hit_arbiter #(
    .N (N_ALIENS)
  ) u_hit_arbiter (
    .req   (live_hits_s),
    .valid (hit_valid_s),
    .index (hit_idx_s)
  );

  assign hunting_s    = (state_r == ST_MARCH) || (state_r == ST_DESCEND);
  assign accept_s     = hunting_s && bullet_active && !lockout_r && hit_valid_s;
  assign kill_bit_s   = ONE_ALIEN << hit_idx_s;
  assign mask_after_s = accept_s ? (enable_r & ~kill_bit_s) : enable_r;
  assign mask_empty_s = (mask_after_s == NO_ALIEN);

  assign step_due_s  = fsync && (cnt_r == STEP_LAST);
  assign clear_due_s = fsync && (cnt_r == CLEAR_LAST);

  assign x_wide_s    = {x_r[11], x_r};
  assign y_wide_s    = {y_r[11], y_r};
  assign y_desc_s    = y_wide_s + STEP_Y_W;
  assign y_over_s    = (y_desc_s >= Y_LIMIT_W);
  assign x_blocked_s = dir_left_r ? ((x_wide_s - STEP_X_W) < X_MIN_W)
                                  : ((x_wide_s + STEP_X_W) > X_MAX_W);

  // State register.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: game over beats wave clear, wave clear beats motion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_s = fsync ? ST_SPAWN : ST_IDLE;
      end
      ST_SPAWN: begin
        state_s = ST_MARCH;
      end
      ST_MARCH: begin
        if (mask_empty_s) begin
          state_s = ST_WAVE_CLEAR;
        end else if (step_due_s && x_blocked_s) begin
          state_s = ST_DESCEND;
        end else begin
          state_s = ST_MARCH;
        end
      end
      ST_DESCEND: begin
        if (fsync && y_over_s) begin
          state_s = ST_GAME_OVER;
        end else if (mask_empty_s) begin
          state_s = ST_WAVE_CLEAR;
        end else if (fsync) begin
          state_s = ST_MARCH;
        end else begin
          state_s = ST_DESCEND;
        end
      end
      ST_WAVE_CLEAR: begin
        state_s = clear_due_s ? ST_SPAWN : ST_WAVE_CLEAR;
      end
      ST_GAME_OVER: begin
        state_s = ST_GAME_OVER;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values: kill bookkeeping runs beside motion.
  always_comb begin
    enable_s    = enable_r;
    x_s         = x_r;
    y_s         = y_r;
    dir_left_s  = dir_left_r;
    cnt_s       = cnt_r;
    score_s     = score_r;
    wave_s      = wave_r;
    hit_index_s = hit_index_r;
    consume_s   = 1'b0;
    lockout_s   = bullet_active ? (lockout_r | accept_s) : 1'b0;

    if (accept_s) begin
      enable_s    = mask_after_s;
      consume_s   = 1'b1;
      hit_index_s = hit_idx_s;
      score_s     = sat_add16(score_r, POINTS_C);
    end else begin
      consume_s   = 1'b0;
    end

    case (state_r)
      ST_SPAWN: begin
        enable_s   = ALL_ALIVE;
        x_s        = X_START_C;
        y_s        = Y_START_C;
        dir_left_s = 1'b0;
        cnt_s      = 16'd0;
        wave_s     = wave_r + 8'd1;
      end
      ST_MARCH: begin
        if (step_due_s) begin
          cnt_s = 16'd0;
          if (x_blocked_s) begin
            x_s = x_r;
          end else begin
            x_s = dir_left_r ? (x_r - STEP_X_C) : (x_r + STEP_X_C);
          end
        end else if (fsync) begin
          cnt_s = cnt_r + 16'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DESCEND: begin
        if (fsync) begin
          y_s        = y_desc_s[11:0];
          dir_left_s = ~dir_left_r;
        end else begin
          y_s        = y_r;
        end
      end
      ST_WAVE_CLEAR: begin
        cnt_s = fsync ? (cnt_r + 16'd1) : cnt_r;
      end
      default: begin
        cnt_s = cnt_r;
      end
    endcase

    // The clear countdown always starts from zero.
    if ((state_s == ST_WAVE_CLEAR) && (state_r != ST_WAVE_CLEAR)) begin
      cnt_s = 16'd0;
    end else begin
      cnt_s = cnt_s;
    end

    game_over_s = (state_s == ST_GAME_OVER) ? 1'b1 : game_over_r;
  end

  // Datapath registers.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      enable_r    <= NO_ALIEN;
      x_r         <= X_START_C;
      y_r         <= Y_START_C;
      dir_left_r  <= 1'b0;
      cnt_r       <= 16'd0;
      score_r     <= 16'd0;
      wave_r      <= 8'd0;
      hit_index_r <= {HIT_IDX_W{1'b0}};
      consume_r   <= 1'b0;
      lockout_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      enable_r    <= enable_s;
      x_r         <= x_s;
      y_r         <= y_s;
      dir_left_r  <= dir_left_s;
      cnt_r       <= cnt_s;
      score_r     <= score_s;
      wave_r      <= wave_s;
      hit_index_r <= hit_index_s;
      consume_r   <= consume_s;
      lockout_r   <= lockout_s;
      game_over_r <= game_over_s;
    end
  end

  assign alien_enable   = enable_r;
  assign formation_x    = x_r;
  assign formation_y    = y_r;
  assign bullet_consume = consume_r;
  assign hit_index      = hit_index_r;
  assign score          = score_r;
  assign wave_num       = wave_r;
  assign game_over      = game_over_r;

endmodule

// File: tb/tb_alien_wave_ctrl.sv
// Self-checking bench for alien_wave_ctrl: directed vectors plus a
// per-cycle shadow reference model driven by random stimulus.
module tb_alien_wave_ctrl;

  localparam int NA     = 8;
  localparam int X0     = 100;
  localparam int Y0     = 40;
  localparam int XLO    = 16;
  localparam int XHI    = 400;
  localparam int DX     = 2;
  localparam int DY     = 8;
  localparam int YLIM   = 400;
  localparam int SFRM   = 2;
  localparam int CFRM   = 60;
  localparam int PTS    = 10;

  localparam int P_IDLE = 0, P_SPAWN = 1, P_MARCH = 2, P_DESCEND = 3, P_CLEAR = 4, P_OVER = 5;

  logic                 clk;
  logic                 rst;
  logic                 fsync;
  logic                 bullet_active;
  logic [NA-1:0]        alien_hit;
  logic [NA-1:0]        alien_enable;
  logic signed [11:0]   formation_x;
  logic signed [11:0]   formation_y;
  logic                 bullet_consume;
  logic [3:0]           hit_index;
  logic [15:0]          score;
  logic [7:0]           wave_num;
  logic                 game_over;

  int checks = 0;
  int errors = 0;
  int shadow_fails = 0;
  bit shadow_on = 1'b0;

  alien_wave_ctrl dut (
    .pixel_clk      (clk),
    .rst            (rst),
    .fsync          (fsync),
    .bullet_active  (bullet_active),
    .alien_hit      (alien_hit),
    .alien_enable   (alien_enable),
    .formation_x    (formation_x),
    .formation_y    (formation_y),
    .bullet_consume (bullet_consume),
    .hit_index      (hit_index),
    .score          (score),
    .wave_num       (wave_num),
    .game_over      (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int         m_phase, m_x, m_y, m_frames, m_clear, m_score, m_wave, m_hidx;
  bit         m_left, m_consume, m_lock, m_go;
  logic [7:0] m_en;

  always @(posedge clk) begin
    int win;
    int ph;
    logic [7:0] live;
    if (rst) begin
      m_phase = P_IDLE; m_en = 8'h00; m_x = X0; m_y = Y0; m_left = 1'b0;
      m_frames = 0; m_clear = 0; m_score = 0; m_wave = 0; m_hidx = 0;
      m_consume = 1'b0; m_lock = 1'b0; m_go = 1'b0;
    end else begin
      ph   = m_phase;
      live = alien_hit & m_en;
      win  = -1;
      if ((ph == P_MARCH || ph == P_DESCEND) && bullet_active && !m_lock)
        for (int i = 0; i < NA; i++) if (win < 0 && live[i]) win = i;
      m_consume = (win >= 0);
      if (win >= 0) begin
        m_en[win] = 1'b0;
        m_hidx    = win;
        m_score   = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
      end
      m_lock = bullet_active && (m_lock || win >= 0);
      case (ph)
        P_IDLE:  if (fsync) m_phase = P_SPAWN;
        P_SPAWN: begin
          m_en = 8'hFF; m_x = X0; m_y = Y0; m_left = 1'b0; m_frames = 0;
          m_wave = (m_wave + 1) % 256; m_phase = P_MARCH;
        end
        P_MARCH: if (fsync) begin
          m_frames++;
          if (m_frames == SFRM) begin
            m_frames = 0;
            if (m_left ? (m_x - DX < XLO) : (m_x + DX > XHI)) m_phase = P_DESCEND;
            else m_x = m_left ? m_x - DX : m_x + DX;
          end
        end
        P_DESCEND: if (fsync) begin
          m_y    = m_y + DY;
          m_left = !m_left;
          if (m_y >= YLIM) begin m_phase = P_OVER; m_go = 1'b1; end
          else m_phase = P_MARCH;
        end
        P_CLEAR: if (fsync) begin
          m_clear++;
          if (m_clear == CFRM) m_phase = P_SPAWN;
        end
        default: ;
      endcase
      if ((ph == P_MARCH || ph == P_DESCEND) && m_phase != P_OVER && m_en == 8'h00) begin
        m_phase = P_CLEAR;
        m_clear = 0;
      end
    end
  end

  // Shadow comparison of every output against the model, once per cycle.
  always @(negedge clk) begin
    logic [63:0] act, exp;
    if (shadow_on) begin
      act = {2'b00, alien_enable, formation_x, formation_y, bullet_consume, hit_index, score, wave_num, game_over};
      exp = {2'b00, m_en, 12'(m_x), 12'(m_y), m_consume, 4'(m_hidx), 16'(m_score), 8'(m_wave), m_go};
      checks++;
      if (act !== exp) begin
        errors++;
        shadow_fails++;
        $display("FAIL shadow @%0t: got %h expected %h", $time, act, exp);
        if (shadow_fails >= 20) shadow_on = 1'b0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    step_cycle();
    fsync = 1'b0;
    step_cycle();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_enable"},  32'(alien_enable), 32'h00);
    check({tag, "_x"},       32'(formation_x), 32'd100);
    check({tag, "_y"},       32'(formation_y), 32'd40);
    check({tag, "_score"},   32'(score), 32'd0);
    check({tag, "_wave"},    32'(wave_num), 32'd0);
    check({tag, "_hidx"},    32'(hit_index), 32'd0);
    check({tag, "_consume"}, 32'(bullet_consume), 32'd0);
    check({tag, "_gameover"},32'(game_over), 32'd0);
  endtask

  typedef struct {
    logic       ba;
    logic [7:0] hit;
    logic       exp_consume;
    logic [3:0] exp_idx;
    logic [7:0] exp_en;
    int         exp_score;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int guard;
    logic [7:0] left_mask;
    bit prev_f;

    vecs[0] = '{1'b1, 8'h24, 1'b1, 4'd2, 8'hFB, 10};
    vecs[1] = '{1'b1, 8'h24, 1'b0, 4'd2, 8'hFB, 10};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 4'd2, 8'hFB, 10};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 4'd2, 8'hFB, 10};
    vecs[4] = '{1'b1, 8'h24, 1'b1, 4'd5, 8'hDB, 20};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 4'd5, 8'hDB, 20};
    vecs[6] = '{1'b1, 8'h80, 1'b1, 4'd7, 8'h5B, 30};
    vecs[7] = '{1'b0, 8'h01, 1'b0, 4'd7, 8'h5B, 30};
    vecs[8] = '{1'b1, 8'h00, 1'b0, 4'd7, 8'h5B, 30};
    vecs[9] = '{1'b1, 8'h03, 1'b1, 4'd0, 8'h5A, 40};

    rst = 1'b1; fsync = 1'b0; bullet_active = 1'b0; alien_hit = 8'h00;
    repeat (3) step_cycle();
    rst = 1'b0;
    shadow_on = 1'b1;
    check_reset("reset");

    // First frame spawns wave 1.
    pulse_fsync();
    check("spawn_enable", 32'(alien_enable), 32'hFF);
    check("spawn_x", 32'(formation_x), 32'd100);
    check("spawn_y", 32'(formation_y), 32'd40);
    check("spawn_wave", 32'(wave_num), 32'd1);

    // Hit arbitration vectors, no frame activity.
    for (int v = 0; v < 10; v++) begin
      bullet_active = vecs[v].ba;
      alien_hit     = vecs[v].hit;
      step_cycle();
      check($sformatf("vec%0d_consume", v), 32'(bullet_consume), 32'(vecs[v].exp_consume));
      check($sformatf("vec%0d_idx", v),     32'(hit_index), 32'(vecs[v].exp_idx));
      check($sformatf("vec%0d_enable", v),  32'(alien_enable), 32'(vecs[v].exp_en));
      check($sformatf("vec%0d_score", v),   32'(score), 32'(vecs[v].exp_score));
    end
    bullet_active = 1'b0; alien_hit = 8'h00;
    step_cycle();

    // Two frames per march step.
    pulse_fsync();
    check("march_one_frame_x", 32'(formation_x), 32'd100);
    pulse_fsync();
    check("march_step_x", 32'(formation_x), 32'd102);

    // Run to the right wall and the first descend.
    guard = 0;
    while (formation_y == 12'sd40 && guard < 2000) begin
      pulse_fsync();
      guard++;
    end
    check("descend_y", 32'(formation_y), 32'd48);
    check("descend_x_held", 32'(formation_x), 32'd400);
    pulse_fsync();
    pulse_fsync();
    check("march_left_x", 32'(formation_x), 32'd398);

    // Finish the wave with separate shots.
    left_mask = alien_enable;
    for (int i = 0; i < NA; i++) begin
      if (left_mask[i]) begin
        bullet_active = 1'b1; alien_hit = 8'h01 << i;
        step_cycle();
        check($sformatf("kill%0d_consume", i), 32'(bullet_consume), 32'd1);
        check($sformatf("kill%0d_idx", i), 32'(hit_index), 32'(i));
        bullet_active = 1'b0; alien_hit = 8'h00;
        step_cycle();
      end
    end
    check("clear_enable", 32'(alien_enable), 32'h00);
    check("clear_score", 32'(score), 32'd80);

    repeat (59) pulse_fsync();
    check("clear_wait_enable", 32'(alien_enable), 32'h00);
    check("clear_wait_wave", 32'(wave_num), 32'd1);
    pulse_fsync();
    check("respawn_enable", 32'(alien_enable), 32'hFF);
    check("respawn_wave", 32'(wave_num), 32'd2);
    check("respawn_x", 32'(formation_x), 32'd100);
    check("respawn_y", 32'(formation_y), 32'd40);

    // March the formation down to the player row.
    guard = 0;
    while (game_over !== 1'b1 && guard < 20000) begin
      pulse_fsync();
      guard++;
    end
    check("gameover_flag", 32'(game_over), 32'd1);
    check("gameover_y", 32'(formation_y), 32'd400);
    check("gameover_x", 32'(formation_x), 32'd400);
    bullet_active = 1'b1; alien_hit = 8'hFF;
    step_cycle();
    check("gameover_no_consume", 32'(bullet_consume), 32'd0);
    pulse_fsync();
    check("gameover_score", 32'(score), 32'd80);
    check("gameover_enable", 32'(alien_enable), 32'hFF);
    check("gameover_sticky", 32'(game_over), 32'd1);
    bullet_active = 1'b0; alien_hit = 8'h00;

    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    check_reset("rst_midgame");

    // Random traffic against the shadow model.
    prev_f = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      fsync         = !prev_f && ($urandom_range(0, 2) == 0);
      prev_f        = fsync;
      bullet_active = ($urandom_range(0, 3) != 0);
      alien_hit     = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rst           = ($urandom_range(0, 499) == 0);
      step_cycle();
    end
    rst = 1'b0; fsync = 1'b0; bullet_active = 1'b0; alien_hit = 8'h00;
    step_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
